wall_follower_ctrl: RTL and testbench

WALL_FOLLOWER_CTRL -- requirements
Module: wall_follower_ctrl

---
 rtl/wall_follower_ctrl.sv | 165 ++++++++++++++++
 tb/tb_wall_follower_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_follower_ctrl.sv
// Wall-following robot controller: debounced front/left sensors drive a
// follow / turn / forward-step FSM with dead-end detection and a saturating move counter.
module wall_follower_ctrl #(
    parameter int DEBOUNCE    = 2,
    parameter int TURN_CYCLES = 4,
    parameter int STUCK_LIMIT = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             front_sensor,
    input  logic             left_sensor,
    output logic             front,
    output logic             turn,
    output logic             turn_left,
    output logic             stuck,
    output logic [CNT_W-1:0] move_count
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int SC_W = $clog2(STUCK_LIMIT + 1);

    localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE - 1);
    localparam logic [TC_W-1:0] TC_LOAD   = TC_W'(TURN_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LIMIT  = SC_W'(STUCK_LIMIT);
    // Index 0 is the front sensor, index 1 the left sensor.
    localparam logic [1:0]      DEB_RESET = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_TURN_R,
        S_TURN_L,
        S_FWD_STEP,
        S_STUCK
    } state_t;

    state_t           state_q, state_d;
    logic [TC_W-1:0]  turn_cnt_q, turn_cnt_d;
    logic [SC_W-1:0]  stuck_cnt_q, stuck_cnt_d;
    logic [SC_W-1:0]  stuck_inc;
    logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
    logic [1:0]       raw;
    logic [1:0]       deb_q, deb_d;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];
    logic             front_deb, left_deb, expired;

    assign raw       = {left_sensor, front_sensor};
    assign front_deb = deb_q[0];
    assign left_deb  = deb_q[1];

    // Each counter tracks how many consecutive samples disagreed with the accepted value.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (raw[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    deb_d[i] = raw[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign expired   = (turn_cnt_q == '0);
    assign stuck_inc = stuck_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        turn_cnt_d  = expired ? turn_cnt_q : turn_cnt_q - 1'b1;
        stuck_cnt_d = stuck_cnt_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_FOLLOW;
                S_FOLLOW: begin
                    if (front_deb) begin
                        state_d    = S_TURN_R;
                        turn_cnt_d = TC_LOAD;
                    end else if (!left_deb) begin
                        state_d    = S_TURN_L;
                        turn_cnt_d = TC_LOAD;
                    end
                end
                S_TURN_R: begin
                    if (expired) begin
                        if (front_deb) begin
                            stuck_cnt_d = stuck_inc;
                            if (stuck_inc == SC_LIMIT) begin
                                state_d = S_STUCK;
                            end else begin
                                turn_cnt_d = TC_LOAD;
                            end
                        end else begin
                            state_d = S_FOLLOW;
                        end
                    end
                end
                S_TURN_L: begin
                    if (expired) begin
                        state_d    = S_FWD_STEP;
                        turn_cnt_d = TC_LOAD;
                    end
                end
                S_FWD_STEP: begin
                    if (front_deb) begin
                        state_d    = S_TURN_R;
                        turn_cnt_d = TC_LOAD;
                    end else if (expired) begin
                        state_d = S_FOLLOW;
                    end
                end
                S_STUCK: state_d = S_STUCK;
                default: state_d = S_IDLE;
            endcase
        end
        // Blocked-burst history only matters across back-to-back right turns.
        if (state_d inside {S_IDLE, S_FOLLOW, S_FWD_STEP}) begin
            stuck_cnt_d = '0;
        end
    end

    assign front     = (state_q == S_FOLLOW) || (state_q == S_FWD_STEP);
    assign turn      = (state_q == S_TURN_R) || (state_q == S_TURN_L);
    assign turn_left = (state_q == S_TURN_L);
    assign stuck     = (state_q == S_STUCK);

    always_comb begin
        move_cnt_d = move_cnt_q;
        if (front && (move_cnt_q != '1)) begin
            move_cnt_d = move_cnt_q + 1'b1;
        end
    end

    assign move_count = move_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            turn_cnt_q  <= '0;
            stuck_cnt_q <= '0;
            move_cnt_q  <= '0;
            deb_q       <= DEB_RESET;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            turn_cnt_q  <= turn_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            move_cnt_q  <= move_cnt_d;
            deb_q       <= deb_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Self-checking bench for wall_follower_ctrl: directed scenarios plus random sensor
// traffic, compared every cycle against a run-length / elapsed-time behavioural model.
module tb_wall_follower_ctrl;

    localparam int DEBOUNCE    = 2;
    localparam int TURN_CYCLES = 4;
    localparam int STUCK_LIMIT = 3;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_FOLLOW = 1;
    localparam int M_TURN_R = 2;
    localparam int M_TURN_L = 3;
    localparam int M_FWD    = 4;
    localparam int M_STUCK  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             front_sensor;
    logic             left_sensor;
    logic             front;
    logic             turn;
    logic             turn_left;
    logic             stuck;
    logic [CNT_W-1:0] move_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mode, m_elapsed, m_blocked, m_mc;
    int m_df, m_dl;
    int f_last, f_run, l_last, l_run;

    wall_follower_ctrl #(
        .DEBOUNCE   (DEBOUNCE),
        .TURN_CYCLES(TURN_CYCLES),
        .STUCK_LIMIT(STUCK_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .front_sensor(front_sensor),
        .left_sensor (left_sensor),
        .front       (front),
        .turn        (turn),
        .turn_left   (turn_left),
        .stuck       (stuck),
        .move_count  (move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_elapsed = 0;
        m_blocked = 0;
        m_mc      = 0;
        m_df      = 0;
        m_dl      = 1;
        f_last    = -1;
        f_run     = 0;
        l_last    = -1;
        l_run     = 0;
    endtask

    // A sensor value is accepted once it has been seen on DEBOUNCE edges in a row.
    task automatic debounce(input int raw, inout int last, inout int run, inout int deb);
        if (raw == last) begin
            run++;
        end else begin
            last = raw;
            run  = 1;
        end
        if (run >= DEBOUNCE) deb = last;
    endtask

    task automatic model_step();
        if ((m_mode == M_FOLLOW || m_mode == M_FWD) && m_mc < CNT_MAX) m_mc++;
        if (!enable) begin
            m_mode    = M_IDLE;
            m_blocked = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode    = M_FOLLOW;
                    m_blocked = 0;
                end
                M_FOLLOW: begin
                    if (m_df != 0) begin
                        m_mode = M_TURN_R; m_elapsed = 0;
                    end else if (m_dl == 0) begin
                        m_mode = M_TURN_L; m_elapsed = 0;
                    end
                end
                M_TURN_R: begin
                    if (m_elapsed == TURN_CYCLES - 1) begin
                        if (m_df != 0) begin
                            m_blocked++;
                            if (m_blocked == STUCK_LIMIT) m_mode = M_STUCK;
                            else m_elapsed = 0;
                        end else begin
                            m_mode    = M_FOLLOW;
                            m_blocked = 0;
                        end
                    end else begin
                        m_elapsed++;
                    end
                end
                M_TURN_L: begin
                    if (m_elapsed == TURN_CYCLES - 1) begin
                        m_mode = M_FWD; m_elapsed = 0; m_blocked = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                M_FWD: begin
                    if (m_df != 0) begin
                        m_mode = M_TURN_R; m_elapsed = 0;
                    end else if (m_elapsed == TURN_CYCLES - 1) begin
                        m_mode = M_FOLLOW; m_blocked = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                default: m_mode = M_STUCK;
            endcase
        end
        debounce(int'(front_sensor), f_last, f_run, m_df);
        debounce(int'(left_sensor), l_last, l_run, m_dl);
    endtask

    task automatic compare_all();
        check("front", 32'(front), 32'(m_mode == M_FOLLOW || m_mode == M_FWD));
        check("turn", 32'(turn), 32'(m_mode == M_TURN_R || m_mode == M_TURN_L));
        check("turn_left", 32'(turn_left), 32'(m_mode == M_TURN_L));
        check("stuck", 32'(stuck), 32'(m_mode == M_STUCK));
        check("move_count", 32'(move_count), 32'(m_mc));
    endtask

    // Starts and ends at a falling edge; inputs change only there.
    task automatic cycle(input logic en, input logic fs, input logic ls);
        enable       = en;
        front_sensor = fs;
        left_sensor  = ls;
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic reset_mid();
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_motion", 32'({front, turn, turn_left, stuck}), 32'd0);
        check("rst_async_count", 32'(move_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic en, fs, ls;
        reset        = 1'b1;
        enable       = 1'b0;
        front_sensor = 1'b0;
        left_sensor  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_outputs", 32'({front, turn, turn_left, stuck}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Enable into FOLLOW, then count five FOLLOW edges
        cycle(1'b1, 1'b0, 1'b1);
        check("follow_after_1_edge", 32'(front), 32'd1);
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        check("move_count_5", 32'(move_count), 32'd5);

        // Single-cycle front glitch is ignored
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        check("glitch_ignored", 32'(front), 32'd1);

        // Held front: right turn two edges later, back to FOLLOW after one burst
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check("turn_r_latency", 32'({turn, turn_left}), 32'b10);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        check("turn_r_last_cycle", 32'(turn), 32'd1);
        cycle(1'b1, 1'b0, 1'b1);
        check("turn_r_to_follow", 32'(front), 32'd1);

        // Front held: three blocked bursts then STUCK, cleared by enable=0
        repeat (14) cycle(1'b1, 1'b1, 1'b1);
        check("third_burst_turning", 32'(turn), 32'd1);
        cycle(1'b1, 1'b1, 1'b1);
        check("stuck_declared", 32'({front, turn, turn_left, stuck}), 32'b0001);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        check("stuck_holds", 32'(stuck), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        check("disable_to_idle", 32'({front, turn, turn_left, stuck}), 32'd0);

        // Left opening: TURN_L, FWD_STEP, then front blocked during the step
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b1);

        // Abort a right turn with an asynchronous reset
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        check("in_turn_r", 32'(turn), 32'd1);
        reset_mid();

        // Saturation of move_count
        repeat (300) cycle(1'b1, 1'b0, 1'b1);
        check("move_count_sat", 32'(move_count), 32'(CNT_MAX));
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        check("move_count_stays", 32'(move_count), 32'(CNT_MAX));
        reset_mid();

        // Random traffic: sensors toggle occasionally, enable rarely drops
        en = 1'b1;
        fs = 1'b0;
        ls = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fs = ~fs;
            if ($urandom_range(0, 3) == 0) ls = ~ls;
            en = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 399) == 0) reset_mid();
            else cycle(en, fs, ls);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
